// File: rtl/ram_access_ctrl_if.sv
// Request/response bus between a client and ram_access_ctrl.
// The client drives the request fields; the controller returns ready and the read response.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Front end for a registered-input single-port RAM: request sequencing, read latency, clear sweep.
// Optional macro CLEAR_VERIFY_EN adds a read-back verify pass after every clear sweep.
//
// state | meaning
// IDLE  | accepting requests; writes complete here at one per cycle
// RD1   | RAM samples the read address
// RD2   | ram_q valid, captured into rsp_rdata with rsp_valid strobe
// CLR   | writing CLEAR_VAL to every address, one per cycle
// VFY   | (CLEAR_VERIFY_EN only) reading back every address and comparing to CLEAR_VAL
module ram_access_ctrl #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clock,
  input  logic                resetn,
  ram_access_ctrl_if.slave    bus,
  input  logic                clear_start,
  output logic                busy,
  output logic                clear_err,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_data,
  output logic                ram_wren,
  input  logic [DATA_W-1:0]   ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    CLR
`ifdef CLEAR_VERIFY_EN
    , VFY
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              accept;

  assign bus.req_ready = (state == IDLE) && !clear_start && resetn;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef CLEAR_VERIFY_EN
  // vfy_iss counts issued reads; its top bit marks "all issued". p1/p2 track reads in the RAM pipe.
  logic [ADDR_W:0] vfy_iss;
  logic            vfy_p1;
  logic            vfy_p2;
  logic            clr_err_q;

  assign clear_err = clr_err_q;
`else
  assign clear_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
`ifdef CLEAR_VERIFY_EN
      vfy_iss     <= '0;
      vfy_p1      <= 1'b0;
      vfy_p2      <= 1'b0;
      clr_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          ram_wren <= 1'b0;
          if (clear_start) begin
            // First sweep write goes out on the start edge so the sweep is exactly 2**ADDR_W cycles.
            state       <= CLR;
            busy        <= 1'b1;
            ram_address <= '0;
            ram_data    <= CLEAR_VAL;
            ram_wren    <= 1'b1;
`ifdef CLEAR_VERIFY_EN
            clr_err_q   <= 1'b0;
`endif
          end else if (accept) begin
            ram_address <= bus.req_addr;
            if (bus.req_write) begin
              ram_data <= bus.req_wdata;
              ram_wren <= 1'b1;
            end else begin
              state <= RD1;
              busy  <= 1'b1;
            end
          end
        end

        RD1: state <= RD2;

        RD2: begin
          rsp_rdata <= ram_q;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        CLR: begin
          if (ram_address == LAST_ADDR) begin
            ram_wren <= 1'b0;
`ifdef CLEAR_VERIFY_EN
            state    <= VFY;
            vfy_iss  <= '0;
            vfy_p1   <= 1'b0;
            vfy_p2   <= 1'b0;
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
          end else begin
            ram_address <= ram_address + 1'b1;
            ram_wren    <= 1'b1;
          end
        end

`ifdef CLEAR_VERIFY_EN
        VFY: begin
          vfy_p2 <= vfy_p1;
          if (!vfy_iss[ADDR_W]) begin
            ram_address <= vfy_iss[ADDR_W-1:0];
            vfy_iss     <= vfy_iss + 1'b1;
            vfy_p1      <= 1'b1;
          end else begin
            vfy_p1 <= 1'b0;
          end
          if (vfy_p2 && (ram_q != CLEAR_VAL)) clr_err_q <= 1'b1;
          if (vfy_p2 && !vfy_p1 && vfy_iss[ADDR_W]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
